// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and frame constants
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_state_e;
endpackage

// File: rtl/uart_rx_oversample_tick.sv
// oversample_tick: baud divider emitting one-cycle ticks, synchronously clearable
module oversample_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // wrap at DIV-1 and pulse tick; clr pins the phase to zero
  always_comb begin
    tick = !clr && cnt_q == CW'(DIV - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  end
  // divider state, active-low synchronous reset
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 16x-oversampled UART receiver with valid/ready holding register; UART_RX_PARITY_EN adds a parity bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE) + 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  uart_state_e state_q, state_d;
  logic sync1_q, sync2_q, rxp_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, perr_q, perr_d, pbad_q, pbad_d;
  logic rx_s, fall, tick, samp, deliver;
  assign rx_s = sync2_q;
  assign fall = rxp_q && !rx_s;
  oversample_tick #(.DIV(DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE && !fall),
    .tick(tick)
  );
  // frame sequencing, sampling, delivery into the holding register and error pulses
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    pbad_d = pbad_q;
    data_d = data_q;
    valid_d = valid_q && !ready;
    ferr_d = 1'b0;
    perr_d = 1'b0;
    deliver = 1'b0;
    samp = tick && tcnt_q == (state_q == START ? TW'(OVERSAMPLE / 2 - 1) : TW'(OVERSAMPLE - 1));
    tcnt_d = samp ? '0 : tick ? tcnt_q + TW'(1) : tcnt_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        bit_d = '0;
        pbad_d = 1'b0;
        state_d = fall ? START : IDLE;
      end
      START: state_d = samp ? (rx_s ? IDLE : DATA) : START;
      DATA: if (samp) begin
        sh_d = {rx_s, sh_q[UART_DATA_BITS-1:1]};
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? (PAR_EN ? PARITY : STOP) : DATA;
      end
      PARITY: if (samp) begin
        pbad_d = (^sh_q ^ rx_s) != PARITY_ODD[0];
        perr_d = pbad_d;
        state_d = STOP;
      end
      STOP: if (samp) begin
        ferr_d = !rx_s;
        deliver = rx_s && !pbad_q;
        state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
    ovr_d = deliver && valid_q && !ready;
    data_d = (deliver && !ovr_d) ? sh_q : data_q;
    valid_d = valid_d || deliver;
  end
  // all receiver state with active-low synchronous reset; sync chain resets to idle-high
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      rxp_q <= 1'b1;
      state_q <= IDLE;
      tcnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
      perr_q <= 1'b0;
      pbad_q <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      rxp_q <= sync2_q;
      state_q <= state_d;
      tcnt_q <= tcnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
      perr_q <= perr_d;
      pbad_q <= pbad_d;
    end
  end
  assign data = data_q;
  assign valid = valid_q;
  assign busy = state_q != IDLE;
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
  assign parity_err = PAR_EN & perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at DIV=10 (160 clocks per bit)
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic ready = 1'b1;
  logic [7:0] data;
  logic valid, busy, frame_err, overrun, parity_err;
  int checks = 0;
  int passed = 0;
  int vcyc = 0, fcnt = 0, ocnt = 0, pcnt = 0;
  int v0, f0, o0, p0;
  logic [7:0] last_data = 8'h00;
  uart_rx #(
    .CLK_FREQ  (1_536_000),
    .BAUD      (9600),
    .OVERSAMPLE(16),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (valid) begin
      vcyc++;
      last_data = data;
    end
    if (frame_err) fcnt++;
    if (overrun) ocnt++;
    if (parity_err) pcnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic snap();
    v0 = vcyc;
    f0 = fcnt;
    o0 = ocnt;
    p0 = pcnt;
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic sb, input logic pb);
    logic [10:0] f;
    int n;
`ifdef UART_RX_PARITY_EN
    f = {sb, pb, b, 1'b0};
    n = 11;
`else
    f = {pb, sb, b, 1'b0};
    n = 10;
`endif
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      repeat (160) @(negedge clk);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    rst = 1'b1;
    idle(50);
    snap();
    send(8'hA5, 1'b1, 1'b0);
    idle(20);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_valid_cycles", vcyc - v0, 1);
    chk("a5_ferr", fcnt - f0, 0);
    chk("a5_ovr", ocnt - o0, 0);
    chk("a5_perr", pcnt - p0, 0);
    chk("a5_busy_after", busy, 1'b0);
    snap();
    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy", busy, 1'b1);
    repeat (10) @(negedge clk);
    idle(300);
    chk("glitch_idle", busy, 1'b0);
    chk("glitch_valid", vcyc - v0, 0);
    chk("glitch_ferr", fcnt - f0, 0);
    snap();
    send(8'h3C, 1'b0, 1'b0);
    chk("ferr_pulse", fcnt - f0, 1);
    chk("ferr_valid", vcyc - v0, 0);
    chk("ferr_busy_low", busy, 1'b1);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    chk("ferr_busy_break", busy, 1'b1);
    idle(10);
    chk("ferr_busy_release", busy, 1'b0);
    idle(100);
    ready = 1'b0;
    snap();
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    idle(20);
    chk("ovr_pulse", ocnt - o0, 1);
    chk("ovr_valid", valid, 1'b1);
    chk("ovr_data", data, 8'h11);
    ready = 1'b1;
    @(negedge clk);
    chk("ovr_drain", valid, 1'b0);
    idle(50);
    rx = 1'b0;
    repeat (160) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 3) ? 1'b0 : 1'b1;
      repeat (160) @(negedge clk);
    end
    rx = 1'b1;
    repeat (80) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_data", data, 8'h00);
    chk("mrst_valid", valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    rst = 1'b1;
    idle(300);
    snap();
    send(8'h5A, 1'b1, 1'b0);
    idle(20);
    chk("5a_data", last_data, 8'h5A);
    chk("5a_valid_cycles", vcyc - v0, 1);
`ifdef UART_RX_PARITY_EN
    snap();
    send(8'h07, 1'b1, 1'b0);
    idle(20);
    chk("par_bad_pulse", pcnt - p0, 1);
    chk("par_bad_valid", vcyc - v0, 0);
    snap();
    send(8'h07, 1'b1, 1'b1);
    idle(20);
    chk("par_ok_data", last_data, 8'h07);
    chk("par_ok_valid", vcyc - v0, 1);
    chk("par_ok_perr", pcnt - p0, 0);
`else
    chk("no_parity_err", pcnt, 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
